// File: rtl/uart_rx_if.sv
// Receive FIFO read handshake: head byte, non-empty flag, pop strobe.
// Latency: none; carries signals only.
// Backpressure: the consumer holds ack low to keep the head entry in place.
interface uart_rx_if;
   logic [7:0] data;
   logic       have_next;
   logic       ack;

   modport master (output data, output have_next, input ack);
   modport slave  (input data, input have_next, output ack);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO (optional even parity: UART_RX_PARITY_EN).
// Latency: byte visible on the cycle after the stop-bit sample; rx input adds 2 sync cycles.
// Backpressure: none on the line; a good byte arriving with the FIFO full (and no ack) is dropped with overrun.
module uart_rx #(
   parameter int ClksPerBit  = 174,
   parameter int FifoPtrBits = 3
) (
   input  logic      clk_i,
   input  logic      reset_i,
   input  logic      rx,
   uart_rx_if.master fifo,
   output logic      rx_interrupt,
   output logic      frame_error,
   output logic      overrun,
   output logic      parity_error
);

   localparam int CntW  = $clog2(ClksPerBit);
   localparam int Depth = 1 << FifoPtrBits;
   // Counter runs down to zero, so the loads are one less than the intervals.
   localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state, state_nxt;
   logic [CntW-1:0]  cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             rx_m, rx_s, rx_q;
   logic             tick, stop_sample, stop_ok, push, pop, full;

   logic [7:0]             mem [Depth];
   logic [FifoPtrBits-1:0] wr_ptr, rd_ptr;
   logic [FifoPtrBits:0]   count;

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_nxt;
`endif

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_q <= rx_s;
      end
   end

   // Receiver state register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_nxt;
`endif
      end
   end

   assign tick = (cnt == '0);

   // Next-state logic: mid-bit sampling driven by the down-counter.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      shift_nxt   = shift;
      stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
`endif
      if (state != S_IDLE && !tick) begin
         cnt_nxt = cnt - 1'b1;
      end
      case (state)
         S_IDLE: begin
            // Only a 1->0 transition starts a frame; a line stuck low does not.
            if (rx_q && !rx_s) begin
               state_nxt = S_START;
               cnt_nxt   = HalfLoad;
`ifdef UART_RX_PARITY_EN
               par_bad_nxt = 1'b0;
`endif
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DATA;
                  cnt_nxt   = BitLoad;
                  idx_nxt   = '0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_nxt = {rx_s, shift[7:1]};
               cnt_nxt   = BitLoad;
               idx_nxt   = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               par_bad_nxt = (rx_s != ^shift);
               cnt_nxt     = BitLoad;
               state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               stop_sample = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign stop_ok = stop_sample && rx_s && !par_bad;
`else
   assign stop_ok = stop_sample && rx_s;
`endif

   assign full = (count == (FifoPtrBits + 1)'(Depth));
   // A full FIFO still accepts when the head is popped in the same cycle.
   assign push = stop_ok && (!full || fifo.ack);
   assign pop  = fifo.ack && (count != '0);

   assign fifo.data      = mem[rd_ptr];
   assign fifo.have_next = (count != '0);

   // FIFO storage and pointers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Status pulses, one cycle each, aligned with the FIFO update.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rx_interrupt <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         rx_interrupt <= push;
         frame_error  <= stop_sample && !rx_s;
         overrun      <= stop_ok && !push;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity mismatch is reported alongside the stop-bit decision.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) parity_error <= 1'b0;
      else          parity_error <= stop_sample && par_bad;
   end
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int RISE   = 2 + CPB / 2 + (NB - 1) * CPB + 1;
   localparam int ACK_AT = RISE - 1;

   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   logic rx = 1'b1;
   logic rx_interrupt, frame_error, overrun, parity_error;

   uart_rx_if fif ();

   uart_rx #(.ClksPerBit(CPB), .FifoPtrBits(3)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .rx(rx), .fifo(fif),
      .rx_interrupt(rx_interrupt), .frame_error(frame_error),
      .overrun(overrun), .parity_error(parity_error)
   );

   always #5 clk_i = ~clk_i;

   int n_run = 0, n_fail = 0;
   int n_int = 0, n_fe = 0, n_ovr = 0, n_pe = 0;
   int exp_int = 0, exp_fe = 0, exp_ovr = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk_i) begin
      if (rx_interrupt === 1'b1) n_int++;
      if (frame_error === 1'b1) n_fe++;
      if (overrun === 1'b1) n_ovr++;
      if (parity_error === 1'b1) n_pe++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Drives one frame; optionally raises ack for one cycle at edge ack_at; reports first have_next rise.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at, output int rise);
      logic bits[NB];
      logic prev;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
      bits[9] = ^b;
`endif
      bits[NB-1] = stop;
      rise = -1;
      prev = fif.have_next;
      for (int k = 0; k < NB * CPB; k++) begin
         if (k % CPB == 0) rx = bits[k / CPB];
         @(posedge clk_i);
         #1;
         if (k + 1 == ack_at) fif.ack = 1'b1;
         if (k + 1 == ack_at + 1) fif.ack = 1'b0;
         if (rise < 0 && !prev && fif.have_next) rise = k + 1;
         prev = fif.have_next;
      end
      rx = 1'b1;
   endtask

   // Scoreboard-side model of the receive FIFO.
   task automatic send_good(input logic [7:0] b);
      int r;
      if (exp_q.size() < 8) begin
         exp_q.push_back(b);
         exp_int++;
      end else begin
         exp_ovr++;
      end
      send_frame(b, 1'b1, 0, r);
   endtask

   task automatic drain(input string name, input int exp_n);
      int n = 0;
      logic [7:0] e;
      for (int i = 0; i < 12 && fif.have_next; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         n_run++;
         if (fif.data !== e) begin
            n_fail++;
            $display("FAIL %s data[%0d]: got %h expected %h", name, n, fif.data, e);
         end
         fif.ack = 1'b1;
         cycles(1);
         fif.ack = 1'b0;
         n++;
      end
      n_run++;
      if (n != exp_n || fif.have_next !== 1'b0) begin
         n_fail++;
         $display("FAIL %s drain_count: got %0d (have_next %b) expected %0d", name, n, fif.have_next, exp_n);
      end
      exp_q.delete();
   endtask

   task automatic check_pulses(input string name);
      n_run++;
      if (n_int != exp_int || n_fe != exp_fe || n_ovr != exp_ovr || n_pe != 0) begin
         n_fail++;
         $display("FAIL %s pulses: int/fe/ovr/pe got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/0",
                  name, n_int, n_fe, n_ovr, n_pe, exp_int, exp_fe, exp_ovr);
      end
   endtask

   task automatic test_reset;
      reset_i = 1'b0;
      fif.ack = 1'b0;
      rx = 1'b1;
      cycles(3);
      n_run++;
      if (fif.data !== 8'h00 || fif.have_next !== 1'b0 || rx_interrupt !== 1'b0 ||
          frame_error !== 1'b0 || overrun !== 1'b0 || parity_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: data=%h hn=%b int=%b fe=%b ovr=%b pe=%b expected all 0",
                  fif.data, fif.have_next, rx_interrupt, frame_error, overrun, parity_error);
      end
      reset_i = 1'b1;
      cycles(4);
   endtask

   task automatic test_single;
      int r;
      exp_int++;
      send_frame(8'hA5, 1'b1, 0, r);
      n_run++;
      if (r != RISE) begin
         n_fail++;
         $display("FAIL single_latency: have_next rose at %0d expected %0d", r, RISE);
      end
      n_run++;
      if (fif.data !== 8'hA5 || fif.have_next !== 1'b1) begin
         n_fail++;
         $display("FAIL single_data: got %h hn=%b expected a5 hn=1", fif.data, fif.have_next);
      end
      check_pulses("single");
      fif.ack = 1'b1;
      cycles(1);
      fif.ack = 1'b0;
      n_run++;
      if (fif.have_next !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: have_next got %b expected 0", fif.have_next);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 9; i++) send_good(8'(i));
      cycles(4);
      check_pulses("b2b_fill");
      drain("b2b_pass1", 8);
      for (int i = 0; i < 8; i++) send_good(8'(8'h10 + i));
      cycles(4);
      check_pulses("b2b_fill2");
      drain("b2b_pass2", 8);
   endtask

   task automatic test_false_start;
      rx = 1'b0;
      cycles(5);
      rx = 1'b1;
      cycles(40);
      check_pulses("false_start");
      n_run++;
      if (fif.have_next !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start_fifo: have_next got %b expected 0", fif.have_next);
      end
      send_good(8'h3C);
      cycles(2);
      drain("false_start_next", 1);
   endtask

   task automatic test_frame_error;
      int r;
      send_frame(8'h3C, 1'b0, 0, r);
      exp_fe++;
      cycles(4);
      check_pulses("frame_error");
      n_run++;
      if (fif.have_next !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_error_push: have_next got %b expected 0", fif.have_next);
      end
      send_good(8'h55);
      cycles(2);
      drain("frame_error_next", 1);
   endtask

   task automatic test_full_ack;
      int r;
      for (int i = 0; i < 8; i++) send_good(8'(8'h20 + i));
      // Head leaves and the new byte enters in the same cycle.
      void'(exp_q.pop_front());
      exp_q.push_back(8'h28);
      exp_int++;
      send_frame(8'h28, 1'b1, ACK_AT, r);
      cycles(4);
      check_pulses("full_ack");
      drain("full_ack", 8);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) send_good(8'(8'hC0 + i));
      rx = 1'b0;
      cycles(CPB);
      rx = 1'b1;
      cycles(3 * CPB);
      reset_i = 1'b0;
      #1;
      n_run++;
      if (fif.data !== 8'h00 || fif.have_next !== 1'b0 || rx_interrupt !== 1'b0 ||
          frame_error !== 1'b0 || overrun !== 1'b0 || parity_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_values: data=%h hn=%b int=%b fe=%b ovr=%b pe=%b expected all 0",
                  fif.data, fif.have_next, rx_interrupt, frame_error, overrun, parity_error);
      end
      exp_q.delete();
      @(posedge clk_i);
      #1;
      cycles(2);
      reset_i = 1'b1;
      cycles(5);
      send_good(8'h81);
      cycles(2);
      check_pulses("reset_mid");
      drain("reset_mid_fresh", 1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_false_start();
      test_frame_error();
      test_full_ack();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the existing `uart` transmitter. It samples an asynchronous serial line in 8N1 format and pushes each good byte into an internal first-word-fall-through FIFO. It exposes the FIFO through the same `data`/`have_next`/`ack` handshake the transmit path uses between `fifo_interleaved` and `uart`. A per-byte pulse can be wired to `n_clic` as an external interrupt source.

## Interface
Parameters:
- `ClksPerBit`, default 174: clock cycles per bit (20 MHz / 115200); must be ≥ 4.
- `FifoPtrBits`, default 3: FIFO depth is 2^FifoPtrBits entries (default 8).

Ports:
- `clk_i`  in  1  system clock; the single clock domain.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk_i`; idles high.
- `ack`  in  1  consumer pops the head entry; ignored when `have_next`=0.
- `data`  out  8  FIFO head byte; valid while `have_next`=1.
- `have_next`  out  1  FIFO non-empty.
- `rx_interrupt`  out  1  one-cycle pulse per byte accepted into the FIFO.
- `frame_error`  out  1  one-cycle pulse; stop bit sampled low.
- `overrun`  out  1  one-cycle pulse; good byte dropped because the FIFO was full.
- `parity_error`  out  1  one-cycle pulse; parity mismatch (see Configuration).

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) to give `rx_s`; one more register holds `rx_q` for edge detection.
- Bit-timing counter is `$clog2(ClksPerBit)` bits wide. Half-bit is `ClksPerBit/2`, integer divide.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: a falling edge (`rx_q`=1, `rx_s`=0) loads the counter and moves to START. A line that is held low does not retrigger.
  - START: at half-bit, sample `rx_s`. If 1, this is a false start: go to IDLE with no pulse. If 0, go to DATA.
  - DATA: sample every `ClksPerBit`, LSB first, into a shift register. Bit index 0..7. After bit 7, go to STOP (or to PARITY when parity is enabled).
  - STOP: sample after one more `ClksPerBit`.
    - 1 and no parity error: push.
    - 0: pulse `frame_error`, discard the byte.
    - Then go to IDLE.
- Push:
  - Accepted if the FIFO is not full, or if it is full and `ack` is asserted in the same cycle. Simultaneous push and pop when full keeps the count at full and the data stays ordered.
  - Otherwise pulse `overrun` and drop the new byte; FIFO contents are unchanged.
  - `rx_interrupt` pulses only on an accepted push.
- FIFO:
  - Read/write pointers are `FifoPtrBits` wide and wrap modulo depth.
  - Count is `FifoPtrBits+1` wide.
  - Full is count == 2^FifoPtrBits; empty is count == 0.
  - Simultaneous push and pop when empty: the push lands and the count becomes 1; the `ack` is ignored.
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE; the partial byte is discarded.
  - FIFO is emptied; pointers and count are 0.
  - Synchronizer and `rx_q` are set to 1.

## Timing
- Reset values: `data`=0x00, `have_next`=0, `rx_interrupt`=0, `frame_error`=0, `overrun`=0, `parity_error`=0.
- Let t0 be the cycle in which `rx_s` first shows the falling edge (2 cycles after `rx` falls).
  - Start sample at t0+`ClksPerBit/2`.
  - Data bit i sample at t0+`ClksPerBit/2`+(i+1)·`ClksPerBit`.
  - Stop sample at t0+`ClksPerBit/2`+9·`ClksPerBit`; add one more `ClksPerBit` when parity is enabled.
- Push, `rx_interrupt`, `frame_error` and `overrun` are all registered on the cycle after the stop sample. `have_next` and `data` update in that same cycle.
- `ack` at cycle n: `data` shows the next entry and `have_next` updates at cycle n+1.
- The receiver is back in IDLE on the cycle after the stop sample, so it accepts a start edge half a bit before the nominal end of the stop bit. Back-to-back frames are sustained.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit follows bit 7; the PARITY state samples it.
  - Mismatch: pulse `parity_error` together with the stop-bit handling and discard the byte.
  - If the stop bit is also 0, `frame_error` pulses as well.
- Not defined:
  - 8N1, no PARITY state.
  - `parity_error` is tied to 0.

## Test plan
Tests use `ClksPerBit`=16 and `FifoPtrBits`=3.
- Single frame 0xA5 with ideal timing:
  - `have_next` rises exactly 2+8+9·16+1 cycles after `rx` falls.
  - `data`=0xA5 and `rx_interrupt` pulses once.
  - `ack` → `have_next`=0 next cycle.
- Nine back-to-back frames 0x00..0x08 with no `ack`:
  - 8 pushes, then `overrun` pulses on the 9th.
  - Draining with `ack` yields 0x00..0x07 in order.
  - Pointers wrap correctly on a second fill/drain pass.
- False start, `rx` low for 5 cycles:
  - No pulses, FIFO unchanged.
  - A following valid 0x3C is received correctly.
- Frame 0x3C with stop bit forced low:
  - `frame_error` pulses; no push, no `rx_interrupt`.
  - The next valid frame 0x55 is received.
- FIFO full while a frame's push coincides with `ack`:
  - No `overrun`; count stays 8.
  - Drain order is the old head+1 … new byte last.
- `reset_i` asserted mid-DATA with 3 bytes queued:
  - All outputs return to their reset values immediately.
  - After release, a fresh frame 0x81 is the only entry.
